// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: sequencer around a Fibonacci LFSR.
// It takes a (seed, count) command, streams count LFSR states over valid/ready,
// then pulses done. It rejects the all-zero seed, flags period wrap-around,
// and supports abort.
module lfsr_seq_ctrl #(
    parameter int                LENGTH  = 16,
    parameter logic [0:LENGTH-1] TAPS    = 16'b0110100000000001,
    parameter int                COUNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [0:LENGTH-1]   seed,
    input  logic [COUNT_W-1:0]  count,
    input  logic                abort,
    output logic                busy,
    output logic [0:LENGTH-1]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                done,
    output logic                err,
    output logic                wrapped
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [0:LENGTH-1]  lfsr_q, lfsr_d;
    logic [0:LENGTH-1]  seed_q, seed_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic               err_q, err_d;
    logic               wrapped_q, wrapped_d;

    logic               fb;
    logic [0:LENGTH-1]  lfsr_next;
    logic               handshake;

    // Feedback enters at bit 0 (leftmost); the rest of the register shifts toward LENGTH-1.
    assign fb        = ^(TAPS & lfsr_q);
    assign lfsr_next = {fb, lfsr_q[0:LENGTH-2]};
    assign handshake = (state_q == S_RUN) && out_ready;

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        // NOTE: every _d gets its hold value first, so a branch that skips an assignment keeps the flop instead of inferring a latch.
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        seed_d      = seed_q;
        remaining_d = remaining_q;
        err_d       = err_q;
        wrapped_d   = wrapped_q;

        unique case (state_q)
            S_IDLE: begin
                // A start here takes priority over abort, which has no effect in IDLE.
                if (start) begin
                    lfsr_d      = seed;
                    seed_d      = seed;
                    remaining_d = count;
                    err_d       = 1'b0;
                    wrapped_d   = 1'b0;
                    if (seed == '0) begin
                        // An all-zero seed would lock the LFSR, so the command ends with nothing emitted.
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // remaining is at least 1 in RUN, so the decrement can never underflow.
                if (handshake) begin
                    lfsr_d      = lfsr_next;
                    remaining_d = remaining_q - CNT_ONE;
                    if (lfsr_next == seed_q) begin
                        wrapped_d = 1'b1;
                    end
                    if (remaining_q == CNT_ONE) begin
                        state_d = S_DONE;
                    end
                end
                // On abort, a word handshaken in the same cycle is still consumed, but the run ends without done.
                if (abort) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously on rst low.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registers use non-blocking assignments, so every flop samples the pre-edge value of the others.
        if (!rst) begin
            state_q     <= S_IDLE;
            lfsr_q      <= '0;
            seed_q      <= '0;
            remaining_q <= '0;
            err_q       <= 1'b0;
            wrapped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            seed_q      <= seed_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
            wrapped_q   <= wrapped_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign out_data  = lfsr_q;
    assign err       = err_q;
    assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb_lfsr_seq_ctrl: directed vectors with hand-computed expected words for a
// default 16-bit instance and for a 4-bit, period-15 instance.
module tb_lfsr_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // 16-bit instance signals
    logic        start = 1'b0;
    logic [0:15] seed  = '0;
    logic [15:0] count = '0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic        busy, out_valid, done, err, wrapped;
    logic [0:15] out_data;

    // 4-bit instance signals
    logic        start4 = 1'b0;
    logic [0:3]  seed4  = '0;
    logic [15:0] count4 = '0;
    logic        abort4 = 1'b0;
    logic        ready4 = 1'b0;
    logic        busy4, valid4, done4, err4, wrapped4;
    logic [0:3]  data4;

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;

    logic [15:0] exp16 [4];
    logic [3:0]  tab4 [15];

    always #5 clk = ~clk;

    lfsr_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed      (seed),
        .count     (count),
        .abort     (abort),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done),
        .err       (err),
        .wrapped   (wrapped)
    );

    lfsr_seq_ctrl #(
        .LENGTH  (4),
        .TAPS    (4'b0011),
        .COUNT_W (16)
    ) dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start4),
        .seed      (seed4),
        .count     (count4),
        .abort     (abort4),
        .busy      (busy4),
        .out_data  (data4),
        .out_valid (valid4),
        .out_ready (ready4),
        .done      (done4),
        .err       (err4),
        .wrapped   (wrapped4)
    );

    // Independent handshake counter for the 16-bit instance.
    always @(posedge clk) begin
        if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Issue one command to the 16-bit instance and follow it through to IDLE.
    // pat gives out_ready per cycle (bit 0 first); poke re-issues start mid-run.
    task automatic run16(input logic [15:0] s, input logic [15:0] c, input logic [6:0] pat,
                         input int plen, input int n, input bit poke);
        int widx = 0;
        int cyc  = 0;
        int hs0;
        @(negedge clk);
        start = 1'b1; seed = s; count = c; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        hs0 = hs_cnt;
        check("run_err_clear", 32'(err), 32'd0);
        while (widx < n && cyc < 200) begin
            check("run_valid", 32'(out_valid), 32'd1);
            check("run_data", 32'(out_data), 32'(exp16[widx]));
            check("run_busy", 32'(busy), 32'd1);
            check("run_no_done", 32'(done), 32'd0);
            out_ready = pat[cyc % plen];
            if (poke && cyc == 1) begin
                start = 1'b1; seed = 16'hFFFF; count = 16'd9;
            end else begin
                start = 1'b0; seed = s; count = c;
            end
            if (out_ready) widx++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b0;
        if (cyc >= 200) check("run_budget", 32'(cyc), 32'd0);
        check("run_done_pulse", 32'(done), 32'd1);
        check("run_done_valid", 32'(out_valid), 32'd0);
        check("run_done_busy", 32'(busy), 32'd1);
        check("run_hs_count", 32'(hs_cnt - hs0), 32'(n));
        check("run_wrapped", 32'(wrapped), 32'd0);
        @(negedge clk);
        check("run_done_once", 32'(done), 32'd0);
        check("run_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        int cyc;
        exp16[0] = 16'h0001; exp16[1] = 16'h8000; exp16[2] = 16'h4000; exp16[3] = 16'hA000;
        tab4[0]  = 4'h1; tab4[1]  = 4'h8; tab4[2]  = 4'h4; tab4[3]  = 4'h2; tab4[4]  = 4'h9;
        tab4[5]  = 4'hC; tab4[6]  = 4'h6; tab4[7]  = 4'hB; tab4[8]  = 4'h5; tab4[9]  = 4'hA;
        tab4[10] = 4'hD; tab4[11] = 4'hE; tab4[12] = 4'hF; tab4[13] = 4'h7; tab4[14] = 4'h3;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wrapped", 32'(wrapped), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Basic run: four words, ready always high
        run16(16'h0001, 16'd4, 7'b1111111, 7, 4, 1'b0);

        // Backpressure 1,0,0,1,1,0,1 with a start poked mid-run (ignored)
        run16(16'h0001, 16'd4, 7'b1011001, 7, 4, 1'b1);

        // Zero seed
        @(negedge clk);
        start = 1'b1; seed = 16'h0000; count = 16'd5;
        @(negedge clk);
        start = 1'b0;
        check("zs_valid", 32'(out_valid), 32'd0);
        check("zs_err", 32'(err), 32'd1);
        check("zs_done", 32'(done), 32'd1);
        check("zs_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("zs_done_once", 32'(done), 32'd0);
        check("zs_idle", 32'(busy), 32'd0);
        check("zs_err_sticky", 32'(err), 32'd1);
        // A good start clears err (checked inside run16)
        run16(16'h0001, 16'd1, 7'b1111111, 7, 1, 1'b0);

        // Zero count
        @(negedge clk);
        start = 1'b1; seed = 16'hACE1; count = 16'd0;
        @(negedge clk);
        start = 1'b0;
        check("zc_valid", 32'(out_valid), 32'd0);
        check("zc_done", 32'(done), 32'd1);
        check("zc_err", 32'(err), 32'd0);
        @(negedge clk);
        check("zc_done_once", 32'(done), 32'd0);
        check("zc_idle", 32'(busy), 32'd0);

        // Wrap: 4-bit period 15, count 20
        @(negedge clk);
        start4 = 1'b1; seed4 = 4'h1; count4 = 16'd20; ready4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        k = 0; cyc = 0;
        while (k < 20 && cyc < 100) begin
            check("wrap_valid", 32'(valid4), 32'd1);
            check("wrap_data", 32'(data4), 32'(tab4[k % 15]));
            check("wrap_flag", 32'(wrapped4), (k >= 15) ? 32'd1 : 32'd0);
            ready4 = 1'b1;
            k++; cyc++;
            @(negedge clk);
        end
        ready4 = 1'b0;
        if (cyc >= 100) check("wrap_budget", 32'(cyc), 32'd0);
        check("wrap_done", 32'(done4), 32'd1);
        check("wrap_done_flag", 32'(wrapped4), 32'd1);
        @(negedge clk);
        check("wrap_idle", 32'(busy4), 32'd0);
        check("wrap_sticky", 32'(wrapped4), 32'd1);

        // Abort after three handshakes, concurrent with a fourth
        @(negedge clk);
        start4 = 1'b1; seed4 = 4'h1; count4 = 16'd20;
        @(negedge clk);
        start4 = 1'b0;
        check("ab_wrap_clear", 32'(wrapped4), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("ab_data", 32'(data4), 32'(tab4[i]));
            ready4 = 1'b1;
            abort4 = (i == 3);
            @(negedge clk);
        end
        abort4 = 1'b0; ready4 = 1'b0;
        check("ab_busy", 32'(busy4), 32'd0);
        check("ab_valid", 32'(valid4), 32'd0);
        check("ab_no_done", 32'(done4), 32'd0);
        check("ab_consumed", 32'(data4), 32'(tab4[4]));
        @(negedge clk);
        check("ab_no_done2", 32'(done4), 32'd0);

        // Asynchronous reset mid-run on both instances
        @(negedge clk);
        start = 1'b1; seed = 16'h0001; count = 16'd30; out_ready = 1'b1;
        start4 = 1'b1; seed4 = 4'h1; count4 = 16'd20; ready4 = 1'b1;
        @(negedge clk);
        start = 1'b0; start4 = 1'b0;
        repeat (17) @(negedge clk);
        check("ar_pre_busy", 32'(busy), 32'd1);
        check("ar_pre_wrapped4", 32'(wrapped4), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_done", 32'(done), 32'd0);
        check("ar_data", 32'(out_data), 32'd0);
        check("ar_busy4", 32'(busy4), 32'd0);
        check("ar_valid4", 32'(valid4), 32'd0);
        check("ar_wrapped4", 32'(wrapped4), 32'd0);
        check("ar_err4", 32'(err4), 32'd0);
        out_ready = 1'b0; ready4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run16(16'h0001, 16'd4, 7'b1111111, 7, 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
